// File: rtl/v2_op_centric_deque.sv
// rtl/v2_op_centric_deque.sv - double-ended queue with push/pop at both ends, each with its own en/rdy pair
// Optional OCQ_OCCUPANCY_EN adds a registered occupancy output.
module v2_op_centric_deque #(
  parameter int p_depth    = 8,
  parameter int p_bitwidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_back_en,
  output logic                  push_back_rdy,
  input  logic [p_bitwidth-1:0] push_back_data,
  input  logic                  push_front_en,
  output logic                  push_front_rdy,
  input  logic [p_bitwidth-1:0] push_front_data,
  input  logic                  pop_front_en,
  output logic                  pop_front_rdy,
  output logic [p_bitwidth-1:0] pop_front_data,
  input  logic                  pop_back_en,
  output logic                  pop_back_rdy,
  output logic [p_bitwidth-1:0] pop_back_data
`ifdef OCQ_OCCUPANCY_EN
  ,
  output logic [$clog2(p_depth+1)-1:0] occupancy
`endif
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);
  localparam logic [PW-1:0] LAST = PW'(p_depth - 1);
  localparam logic [CW-1:0] FULL = CW'(p_depth);

  // Pointers wrap modulo p_depth so non-power-of-2 depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  logic [p_bitwidth-1:0] mem [p_depth];
  logic [PW-1:0]         head, tail, head_nxt, tail_nxt, head_m1, tail_m1, wr_addr;
  logic [CW-1:0]         count, count_nxt;
  logic [p_bitwidth-1:0] wr_data;
  logic                  do_push_back, do_push_front, do_pop_front, do_pop_back;
  logic                  do_push, do_pop;

  assign push_back_rdy  = (count != FULL);
  assign push_front_rdy = (count != FULL);
  assign pop_front_rdy  = (count != '0);
  assign pop_back_rdy   = (count != '0);

  assign head_m1 = ptr_dec(head);
  assign tail_m1 = ptr_dec(tail);

  // push_back beats push_front, pop_front beats pop_back
  assign do_push_back  = push_back_en & push_back_rdy;
  assign do_push_front = push_front_en & push_front_rdy & ~push_back_en;
  assign do_pop_front  = pop_front_en & pop_front_rdy;
  assign do_pop_back   = pop_back_en & pop_back_rdy & ~pop_front_en;
  assign do_push       = do_push_back | do_push_front;
  assign do_pop        = do_pop_front | do_pop_back;

  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    wr_addr   = tail;
    wr_data   = push_back_data;
    // A push and pop at the same end reuse the freed slot and leave that pointer alone
    if (do_push_back) begin
      wr_addr = do_pop_back ? tail_m1 : tail;
      if (!do_pop_back) tail_nxt = ptr_inc(tail);
    end else if (do_push_front) begin
      wr_data = push_front_data;
      wr_addr = do_pop_front ? head : head_m1;
      if (!do_pop_front) head_nxt = head_m1;
    end
    if (do_pop_front && !do_push_front) head_nxt = ptr_inc(head);
    if (do_pop_back && !do_push_back)   tail_nxt = tail_m1;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      pop_front_data <= '0;
      pop_back_data  <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      if (do_pop_front) pop_front_data <= mem[head];
      if (do_pop_back)  pop_back_data  <= mem[tail_m1];
    end
  end

`ifdef OCQ_OCCUPANCY_EN
  assign occupancy = count;
`endif

endmodule

// File: tb/tb_v2_op_centric_deque.sv
// tb/tb_v2_op_centric_deque.sv - scoreboard bench driving a depth-4/8-bit and a depth-5/16-bit deque in lockstep
module tb_v2_op_centric_deque;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        pb_en, pf_en, pof_en, pob_en;
  logic [15:0] pb_d, pf_d;

  logic        pbr4, pfr4, pofr4, pobr4;
  logic [7:0]  pofd4, pobd4;
  logic        pbr5, pfr5, pofr5, pobr5;
  logic [15:0] pofd5, pobd5;
`ifdef OCQ_OCCUPANCY_EN
  logic [2:0]  occ4, occ5;
`endif

  v2_op_centric_deque #(.p_depth(4), .p_bitwidth(8)) dut4 (
    .clk(clk), .rst(rst),
    .push_back_en(pb_en),   .push_back_rdy(pbr4),  .push_back_data(pb_d[7:0]),
    .push_front_en(pf_en),  .push_front_rdy(pfr4), .push_front_data(pf_d[7:0]),
    .pop_front_en(pof_en),  .pop_front_rdy(pofr4), .pop_front_data(pofd4),
    .pop_back_en(pob_en),   .pop_back_rdy(pobr4),  .pop_back_data(pobd4)
`ifdef OCQ_OCCUPANCY_EN
    , .occupancy(occ4)
`endif
  );

  v2_op_centric_deque #(.p_depth(5), .p_bitwidth(16)) dut5 (
    .clk(clk), .rst(rst),
    .push_back_en(pb_en),   .push_back_rdy(pbr5),  .push_back_data(pb_d),
    .push_front_en(pf_en),  .push_front_rdy(pfr5), .push_front_data(pf_d),
    .pop_front_en(pof_en),  .pop_front_rdy(pofr5), .pop_front_data(pofd5),
    .pop_back_en(pob_en),   .pop_back_rdy(pobr5),  .pop_back_data(pobd5)
`ifdef OCQ_OCCUPANCY_EN
    , .occupancy(occ5)
`endif
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] m4[$], m5[$];
  logic [15:0] sb_f4[$], sb_b4[$], sb_f5[$], sb_b5[$];
  logic [15:0] last_f4, last_b4, last_f5, last_b5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic pb, input logic [15:0] pbd, input logic pf, input logic [15:0] pfd,
                      input logic pof, input logic pob);
    bit can_push4, can_pop4, can_push5, can_pop5;
    can_push4 = (m4.size() < 4);
    can_pop4  = (m4.size() > 0);
    can_push5 = (m5.size() < 5);
    can_pop5  = (m5.size() > 0);
    pb_en = pb; pb_d = pbd; pf_en = pf; pf_d = pfd; pof_en = pof; pob_en = pob;
    check_eq("push_back_rdy4",  pbr4,  can_push4);
    check_eq("push_front_rdy4", pfr4,  can_push4);
    check_eq("pop_front_rdy4",  pofr4, can_pop4);
    check_eq("pop_back_rdy4",   pobr4, can_pop4);
    check_eq("push_back_rdy5",  pbr5,  can_push5);
    check_eq("push_front_rdy5", pfr5,  can_push5);
    check_eq("pop_front_rdy5",  pofr5, can_pop5);
    check_eq("pop_back_rdy5",   pobr5, can_pop5);
    // reference model: pop from the pre-state first, then push
    if (pof && can_pop4)      sb_f4.push_back(m4.pop_front());
    else if (pob && can_pop4) sb_b4.push_back(m4.pop_back());
    if (pb && can_push4)      m4.push_back(pbd & 16'h00ff);
    else if (pf && can_push4) m4.push_front(pfd & 16'h00ff);
    if (pof && can_pop5)      sb_f5.push_back(m5.pop_front());
    else if (pob && can_pop5) sb_b5.push_back(m5.pop_back());
    if (pb && can_push5)      m5.push_back(pbd);
    else if (pf && can_push5) m5.push_front(pfd);
    @(posedge clk);
    #1;
    if (sb_f4.size() > 0) last_f4 = sb_f4.pop_front();
    if (sb_b4.size() > 0) last_b4 = sb_b4.pop_front();
    if (sb_f5.size() > 0) last_f5 = sb_f5.pop_front();
    if (sb_b5.size() > 0) last_b5 = sb_b5.pop_front();
    check_eq("pop_front_data4", pofd4, last_f4);
    check_eq("pop_back_data4",  pobd4, last_b4);
    check_eq("pop_front_data5", pofd5, last_f5);
    check_eq("pop_back_data5",  pobd5, last_b5);
`ifdef OCQ_OCCUPANCY_EN
    check_eq("occupancy4", occ4, m4.size());
    check_eq("occupancy5", occ5, m5.size());
`endif
  endtask

  task automatic idle_inputs();
    pb_en = 1'b0; pf_en = 1'b0; pof_en = 1'b0; pob_en = 1'b0;
    pb_d = '0; pf_d = '0;
  endtask

  // reset is raised mid-cycle and its effect is checked before the next edge
  task automatic do_reset();
    idle_inputs();
    #3 rst = 1'b1;
    #1;
    check_eq("rst_pop_front_data4", pofd4, 0);
    check_eq("rst_pop_back_data4",  pobd4, 0);
    check_eq("rst_pop_front_data5", pofd5, 0);
    check_eq("rst_pop_back_data5",  pobd5, 0);
    check_eq("rst_push_rdy4", {pbr4, pfr4}, 2'b11);
    check_eq("rst_pop_rdy4",  {pofr4, pobr4}, 2'b00);
    check_eq("rst_push_rdy5", {pbr5, pfr5}, 2'b11);
    check_eq("rst_pop_rdy5",  {pofr5, pobr5}, 2'b00);
`ifdef OCQ_OCCUPANCY_EN
    check_eq("rst_occupancy4", occ4, 0);
    check_eq("rst_occupancy5", occ5, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    m4.delete(); m5.delete();
    sb_f4.delete(); sb_b4.delete(); sb_f5.delete(); sb_b5.delete();
    last_f4 = '0; last_b4 = '0; last_f5 = '0; last_b5 = '0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // FIFO order and full/empty rdy
    step(1, 16'h11, 0, 0, 0, 0);
    step(1, 16'h22, 0, 0, 0, 0);
    step(1, 16'h33, 0, 0, 0, 0);
    step(1, 16'h44, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);

    // stack order through push_front, head wraps
    step(0, 0, 1, 16'h11, 0, 0);
    step(0, 0, 1, 16'h22, 0, 0);
    step(0, 0, 1, 16'h33, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

    // mixed ends
    step(1, 16'h11, 0, 0, 0, 0);
    step(1, 16'h22, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h55, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);

    // simultaneous push and pop at every end pairing
    step(1, 16'h11, 0, 0, 0, 0);
    step(1, 16'h22, 0, 0, 0, 0);
    step(1, 16'h99, 0, 0, 1, 0);
    step(1, 16'h77, 0, 0, 0, 1);
    step(0, 0, 1, 16'h66, 1, 0);
    step(0, 0, 1, 16'h88, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // full: extra push ignored on depth 4, then reset mid-operation
    step(1, 16'h01, 0, 0, 0, 0);
    step(1, 16'h02, 0, 0, 0, 0);
    step(1, 16'h03, 0, 0, 0, 0);
    step(1, 16'h04, 0, 0, 0, 0);
    step(1, 16'h05, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    do_reset();

    // both pushes at once: only the back push lands
    for (int i = 0; i < 6; i++) step(1, 16'hA0 + 16'(i), 1, 16'hB0 + 16'(i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);

    // random traffic to exercise wrap at both depths
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
